// File: rtl/issue_wakeup_stage.sv
// Single-entry issue/wakeup stage between the issue FIFO and a functional unit.
// Holds one micro-op until both sources are woken by the CDB, then offers it to the FU.
module issue_wakeup_stage #(
    parameter int PREG_W    = 7,
    parameter int PAYLOAD_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 fifo_empty,
    output logic                 fifo_read_en,
    input  logic [PREG_W-1:0]    fifo_src1_tag,
    input  logic [PREG_W-1:0]    fifo_src2_tag,
    input  logic                 fifo_src1_rdy,
    input  logic                 fifo_src2_rdy,
    input  logic [PAYLOAD_W-1:0] fifo_payload,
    input  logic                 cdb0_valid,
    input  logic                 cdb1_valid,
    input  logic [PREG_W-1:0]    cdb0_tag,
    input  logic [PREG_W-1:0]    cdb1_tag,
    output logic                 fu_valid,
    input  logic                 fu_ready,
    output logic [PAYLOAD_W-1:0] fu_payload,
    output logic [15:0]          stall_count
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ISSUE
    } state_t;

    state_t              state;
    logic [PREG_W-1:0]   src1_tag;
    logic [PREG_W-1:0]   src2_tag;
    logic                src1_rdy;
    logic                src2_rdy;

    logic                hs;
    logic                pop;
    logic                stall;
    logic                head1_rdy;
    logic                head2_rdy;
    logic                held1_rdy;
    logic                held2_rdy;

    // Pop/handshake decisions and CDB wakeup matches for head and held entry
    always_comb begin
        hs        = (state == ISSUE) & fu_ready;
        pop       = rst & ~flush & ~fifo_empty & ((state == IDLE) | hs);
        stall     = (state == WAIT) | ((state == ISSUE) & ~fu_ready);
        head1_rdy = fifo_src1_rdy
                  | (cdb0_valid & (cdb0_tag == fifo_src1_tag))
                  | (cdb1_valid & (cdb1_tag == fifo_src1_tag));
        head2_rdy = fifo_src2_rdy
                  | (cdb0_valid & (cdb0_tag == fifo_src2_tag))
                  | (cdb1_valid & (cdb1_tag == fifo_src2_tag));
        held1_rdy = src1_rdy
                  | (cdb0_valid & (cdb0_tag == src1_tag))
                  | (cdb1_valid & (cdb1_tag == src1_tag));
        held2_rdy = src2_rdy
                  | (cdb0_valid & (cdb0_tag == src2_tag))
                  | (cdb1_valid & (cdb1_tag == src2_tag));
    end

    assign fifo_read_en = pop;

    // Holding register FSM with registered fu_valid and saturating stall counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            fu_valid    <= 1'b0;
            fu_payload  <= '0;
            src1_tag    <= '0;
            src2_tag    <= '0;
            src1_rdy    <= 1'b0;
            src2_rdy    <= 1'b0;
            stall_count <= 16'd0;
        end else begin
            if (stall && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
            if (flush) begin
                state    <= IDLE;
                fu_valid <= 1'b0;
                src1_rdy <= 1'b0;
                src2_rdy <= 1'b0;
            end else if (pop) begin
                fu_payload <= fifo_payload;
                src1_tag   <= fifo_src1_tag;
                src2_tag   <= fifo_src2_tag;
                src1_rdy   <= head1_rdy;
                src2_rdy   <= head2_rdy;
                if (head1_rdy && head2_rdy) begin
                    state    <= ISSUE;
                    fu_valid <= 1'b1;
                end else begin
                    state    <= WAIT;
                    fu_valid <= 1'b0;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        fu_valid <= 1'b0;
                    end
                    WAIT: begin
                        src1_rdy <= held1_rdy;
                        src2_rdy <= held2_rdy;
                        if (held1_rdy && held2_rdy) begin
                            state    <= ISSUE;
                            fu_valid <= 1'b1;
                        end
                    end
                    ISSUE: begin
                        if (fu_ready) begin
                            state    <= IDLE;
                            fu_valid <= 1'b0;
                            src1_rdy <= 1'b0;
                            src2_rdy <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        fu_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_issue_wakeup_stage.sv
// Directed and randomized bench for issue_wakeup_stage.
// Reference model tracks one held entry, its ready bits and a stall counter.
module tb_issue_wakeup_stage;

    localparam int PW = 7;
    localparam int DW = 64;

    typedef struct {
        logic [PW-1:0] t1;
        logic [PW-1:0] t2;
        logic          r1;
        logic          r2;
        logic [DW-1:0] pl;
    } ent_t;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          fifo_empty;
    logic          fifo_read_en;
    logic [PW-1:0] fifo_src1_tag;
    logic [PW-1:0] fifo_src2_tag;
    logic          fifo_src1_rdy;
    logic          fifo_src2_rdy;
    logic [DW-1:0] fifo_payload;
    logic          cdb0_valid;
    logic          cdb1_valid;
    logic [PW-1:0] cdb0_tag;
    logic [PW-1:0] cdb1_tag;
    logic          fu_valid;
    logic          fu_ready;
    logic [DW-1:0] fu_payload;
    logic [15:0]   stall_count;

    issue_wakeup_stage #(.PREG_W(PW), .PAYLOAD_W(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .fifo_empty    (fifo_empty),
        .fifo_read_en  (fifo_read_en),
        .fifo_src1_tag (fifo_src1_tag),
        .fifo_src2_tag (fifo_src2_tag),
        .fifo_src1_rdy (fifo_src1_rdy),
        .fifo_src2_rdy (fifo_src2_rdy),
        .fifo_payload  (fifo_payload),
        .cdb0_valid    (cdb0_valid),
        .cdb1_valid    (cdb1_valid),
        .cdb0_tag      (cdb0_tag),
        .cdb1_tag      (cdb1_tag),
        .fu_valid      (fu_valid),
        .fu_ready      (fu_ready),
        .fu_payload    (fu_payload),
        .stall_count   (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ent_t          q[$];
    bit            m_held;
    bit            m_r1;
    bit            m_r2;
    logic [PW-1:0] m_t1;
    logic [PW-1:0] m_t2;
    logic [DW-1:0] m_pl;
    int            m_stall;

    int  errors;
    int  checks;
    bit  quiet;
    bit  last_rd;
    int  n_pop;
    int  n_fv;
    int  n_hs;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit wk(input logic [PW-1:0] t);
        return (cdb0_valid && cdb0_tag == t) || (cdb1_valid && cdb1_tag == t);
    endfunction

    function automatic ent_t mk(input logic [PW-1:0] t1, input bit r1,
                                input logic [PW-1:0] t2, input bit r2,
                                input logic [DW-1:0] pl);
        ent_t e;
        e.t1 = t1;
        e.r1 = r1;
        e.t2 = t2;
        e.r2 = r2;
        e.pl = pl;
        return e;
    endfunction

    function automatic logic [PW-1:0] rtag();
        logic [PW-1:0] t;
        if ($urandom_range(0, 4) == 4) t = 7'h7F;
        else t = 7'($urandom_range(0, 3));
        return t;
    endfunction

    // One clock: drive head, check outputs against model, advance model
    task automatic step();
        bit e_fv;
        bit e_pop;
        if (q.size() > 0) begin
            fifo_empty    = 1'b0;
            fifo_src1_tag = q[0].t1;
            fifo_src2_tag = q[0].t2;
            fifo_src1_rdy = q[0].r1;
            fifo_src2_rdy = q[0].r2;
            fifo_payload  = q[0].pl;
        end else begin
            fifo_empty    = 1'b1;
        end
        if (!rst) begin
            m_held  = 0;
            m_r1    = 0;
            m_r2    = 0;
            m_stall = 0;
            m_pl    = '0;
        end
        #1;
        e_fv  = m_held && m_r1 && m_r2;
        e_pop = rst && !flush && q.size() > 0 &&
                (!m_held || (e_fv && fu_ready));
        last_rd = fifo_read_en;
        if (fu_valid) n_fv++;
        if (fifo_read_en) n_pop++;
        if (fu_valid && fu_ready) n_hs++;
        if (!quiet) begin
            chk("read_en", fifo_read_en, e_pop);
            chk("fu_valid", fu_valid, e_fv);
            chk("stall_count", stall_count, m_stall);
            if (e_fv) chk("fu_payload", fu_payload, m_pl);
            if (!rst) chk("reset_payload", fu_payload, 0);
        end
        @(posedge clk);
        if (rst) begin
            if (m_held && !(e_fv && fu_ready) && m_stall < 65535) m_stall++;
            if (flush) begin
                m_held = 0;
                m_r1   = 0;
                m_r2   = 0;
            end else if (e_pop) begin
                m_held = 1;
                m_t1   = q[0].t1;
                m_t2   = q[0].t2;
                m_r1   = q[0].r1 || wk(q[0].t1);
                m_r2   = q[0].r2 || wk(q[0].t2);
                m_pl   = q[0].pl;
                void'(q.pop_front());
            end else if (m_held) begin
                if (e_fv && fu_ready) begin
                    m_held = 0;
                end else begin
                    m_r1 = m_r1 || wk(m_t1);
                    m_r2 = m_r2 || wk(m_t2);
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        flush      = 1'b0;
        cdb0_valid = 1'b0;
        cdb1_valid = 1'b0;
        fu_ready   = 1'b0;
        q.delete();
        step();
        step();
        rst = 1'b1;
        n_pop = 0;
        n_fv  = 0;
        n_hs  = 0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        quiet  = 0;
        rst    = 1'b1;
        flush  = 1'b0;
        fifo_empty    = 1'b1;
        fifo_src1_tag = '0;
        fifo_src2_tag = '0;
        fifo_src1_rdy = 1'b0;
        fifo_src2_rdy = 1'b0;
        fifo_payload  = '0;
        cdb0_valid = 1'b0;
        cdb1_valid = 1'b0;
        cdb0_tag   = '0;
        cdb1_tag   = '0;
        fu_ready   = 1'b0;
        #2;

        // Reset with a non-empty FIFO: no pop, all outputs cleared
        rst = 1'b0;
        q.push_back(mk(7'h01, 1, 7'h02, 1, 64'h1111));
        step();
        chk("rst_read_en", last_rd, 0);
        chk("rst_fu_valid", fu_valid, 0);
        chk("rst_stall", stall_count, 0);
        // First pop at the first edge after reset release
        rst = 1'b1;
        fu_ready = 1'b1;
        step();
        chk("first_pop", last_rd, 1);
        chk("first_fv", fu_valid, 1);

        // Three ready entries issue back to back
        do_reset();
        fu_ready = 1'b1;
        for (int i = 0; i < 3; i++)
            q.push_back(mk(7'(i), 1, 7'(i + 8), 1, 64'(100 + i)));
        repeat (5) step();
        chk("b2b_pops", n_pop, 3);
        chk("b2b_fv_cycles", n_fv, 3);
        chk("b2b_stall", stall_count, 0);

        // Same-cycle wakeup on cdb1 while capturing
        do_reset();
        q.push_back(mk(7'h01, 1, 7'h12, 0, 64'h2222));
        cdb1_valid = 1'b1;
        cdb1_tag   = 7'h12;
        step();
        cdb1_valid = 1'b0;
        chk("samecyc_fv", fu_valid, 1);
        chk("samecyc_stall", stall_count, 0);

        // Late wakeup on cdb0 after four waiting cycles
        do_reset();
        q.push_back(mk(7'h05, 0, 7'h06, 1, 64'h3333));
        step();
        repeat (3) step();
        chk("late_fv_low", fu_valid, 0);
        cdb0_valid = 1'b1;
        cdb0_tag   = 7'h05;
        step();
        cdb0_valid = 1'b0;
        chk("late_fv", fu_valid, 1);
        chk("late_stall", stall_count, 4);

        // Backpressure from the FU holds payload
        do_reset();
        q.push_back(mk(7'h00, 1, 7'h00, 1, 64'hDEAD));
        step();
        repeat (3) begin
            step();
            chk("bp_payload", fu_payload, 64'hDEAD);
            chk("bp_no_pop", last_rd, 0);
        end
        chk("bp_stall", stall_count, 3);
        fu_ready = 1'b1;
        step();
        chk("bp_handshakes", n_hs, 1);
        chk("bp_fv_after", fu_valid, 0);
        chk("bp_stall_after", stall_count, 3);

        // Flush in WAIT, then flush during an ISSUE handshake
        do_reset();
        fu_ready = 1'b1;
        q.push_back(mk(7'h40, 0, 7'h41, 1, 64'h4444));
        q.push_back(mk(7'h42, 1, 7'h43, 1, 64'h5555));
        q.push_back(mk(7'h44, 1, 7'h45, 1, 64'h6666));
        step();
        step();
        flush = 1'b1;
        step();
        chk("flush_wait_nopop", last_rd, 0);
        chk("flush_fv", fu_valid, 0);
        flush = 1'b0;
        step();
        chk("flush_pop_after", last_rd, 1);
        flush = 1'b1;
        step();
        chk("flush_issue_nopop", last_rd, 0);
        chk("flush_issue_fv", fu_valid, 0);
        flush = 1'b0;

        // Asynchronous reset in the middle of WAIT
        do_reset();
        q.push_back(mk(7'h50, 0, 7'h51, 0, 64'h7777));
        q.push_back(mk(7'h52, 1, 7'h53, 1, 64'h8888));
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        chk("async_fv", fu_valid, 0);
        chk("async_read_en", fifo_read_en, 0);
        chk("async_stall", stall_count, 0);
        chk("async_payload", fu_payload, 0);
        step();
        rst = 1'b1;
        fu_ready = 1'b1;
        step();
        chk("async_repop", last_rd, 1);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0 && q.size() < 4)
                q.push_back(mk(rtag(), 1'($urandom_range(0, 1)), rtag(),
                               1'($urandom_range(0, 1)),
                               {$urandom, $urandom}));
            cdb0_valid = 1'($urandom_range(0, 1));
            cdb1_valid = 1'($urandom_range(0, 1));
            cdb0_tag   = rtag();
            cdb1_tag   = rtag();
            fu_ready   = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            step();
        end
        flush      = 1'b0;
        cdb0_valid = 1'b0;
        cdb1_valid = 1'b0;

        // Stall counter saturation
        do_reset();
        q.push_back(mk(7'h33, 0, 7'h34, 1, 64'h9999));
        quiet = 1;
        repeat (65540) step();
        quiet = 0;
        chk("sat_stall", stall_count, 16'hFFFF);
        step();
        chk("sat_nowrap", stall_count, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
